// File: rtl/router_pkg.sv
// Shared definitions for the tail-bit reset transmitter: FSM state type,
// parameter defaults and a small helper for sizing the phase counter.
package router_pkg;

    typedef enum logic [1:0] {
        ST_PASS   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ASSERT = 2'd2,
        ST_GUARD  = 2'd3
    } tbr_state_t;

    localparam int TBR_W_DEF            = 20;
    localparam int TBR_RX_N_DEF         = 3;
    localparam int TBR_HOLD_CYCLES_DEF  = 8;
    localparam int TBR_GUARD_CYCLES_DEF = 16;

    function automatic int tbr_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tail_bit_reset_tx_down_counter.sv
// Loadable down counter that saturates at zero; used to time the ASSERT
// and GUARD phases of the tail-bit reset sequence.
module tbr_down_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          zero_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load wins over enable; decrement stops at zero so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/tail_bit_reset_tx.sv
// Link transmitter that passes words through combinationally and, on request,
// resets the downstream board by holding the tail pin high, then idling quietly.
module tail_bit_reset_tx
    import router_pkg::*;
#(
    parameter int W            = TBR_W_DEF,
    parameter int RX_N         = TBR_RX_N_DEF,
    parameter int HOLD_CYCLES  = TBR_HOLD_CYCLES_DEF,
    parameter int GUARD_CYCLES = TBR_GUARD_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rst_req,
    input  logic [W-1:0] data_in,
    input  logic         data_tail,
    input  logic         data_valid,
    output logic         data_ready,
    output logic [W-1:0] link_data,
    output logic         link_tail,
    output logic         link_valid,
    input  logic         link_ready,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(tbr_max(HOLD_CYCLES, GUARD_CYCLES) + 1);
    localparam int RW = $clog2(RX_N + 1);

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [RW-1:0] RUN_LIMIT  = RW'(RX_N - 1);

    tbr_state_t    state_q, state_d;
    logic          in_pkt_q, in_pkt_d;
    logic          req_pend_q, req_pend_d;
    logic [RW-1:0] run_q, run_d;

    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_en;
    logic          cnt_zero;

    logic          bubble;
    logic          link_state;
    logic          passing;
    logic          lv;
    logic          rdy;
    logic          lt;
    logic          accept;

    // A forced low cycle after RX_N-1 tail highs keeps ordinary traffic from
    // ever looking like a reset command to the receiver.
    assign bubble     = (run_q == RUN_LIMIT);
    assign link_state = (state_q == ST_PASS) || (state_q == ST_DRAIN);
    assign passing    = (state_q == ST_PASS) || ((state_q == ST_DRAIN) && in_pkt_q);

    assign lv     = passing && data_valid && !bubble;
    assign rdy    = passing && link_ready && !bubble;
    assign lt     = (state_q == ST_ASSERT) || (data_tail && lv);
    assign accept = data_valid && rdy;

    assign link_data  = data_in;
    assign link_valid = !reset && lv;
    assign data_ready = !reset && rdy;
    assign link_tail  = !reset && lt;
    assign busy       = !reset && (state_q != ST_PASS);
    assign done       = !reset && (state_q == ST_GUARD) && cnt_zero;

    assign cnt_en = (state_q == ST_ASSERT) || (state_q == ST_GUARD);

    always_comb begin
        state_d    = state_q;
        in_pkt_d   = in_pkt_q;
        req_pend_d = req_pend_q;
        run_d      = '0;
        cnt_load   = 1'b0;
        cnt_val    = '0;

        if (accept) begin
            in_pkt_d = !data_tail;
        end
        if (link_state && lt) begin
            run_d = run_q + 1'b1;
        end

        case (state_q)
            ST_PASS: begin
                // A request colliding with a bubble is held over to the next cycle.
                if (rst_req || req_pend_q) begin
                    if (bubble) begin
                        req_pend_d = 1'b1;
                    end else begin
                        req_pend_d = 1'b0;
                        if (!in_pkt_q && !accept) begin
                            state_d  = ST_ASSERT;
                            cnt_load = 1'b1;
                            cnt_val  = HOLD_LOAD;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!in_pkt_q || (accept && data_tail)) begin
                    state_d  = ST_ASSERT;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LOAD;
                end
            end
            ST_ASSERT: begin
                if (cnt_zero) begin
                    state_d  = ST_GUARD;
                    cnt_load = 1'b1;
                    cnt_val  = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                if (cnt_zero) begin
                    state_d = ST_PASS;
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_PASS;
            in_pkt_q   <= 1'b0;
            req_pend_q <= 1'b0;
            run_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_pkt_q   <= in_pkt_d;
            req_pend_q <= req_pend_d;
            run_q      <= run_d;
        end
    end

    tbr_down_counter #(
        .CW(CW)
    ) u_phase_cnt (
        .clk        (clk),
        .srst       (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

endmodule

// File: tb/tb_tail_bit_reset_tx.sv
// Bench for tail_bit_reset_tx: directed scenarios plus random traffic, all
// checked cycle by cycle against a time-window reference model.
module tb_tail_bit_reset_tx;

    localparam int W     = 20;
    localparam int RX_N  = 3;
    localparam int HOLD  = 8;
    localparam int GUARD = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         rst_req;
    logic [W-1:0] data_in;
    logic         data_tail;
    logic         data_valid;
    logic         data_ready;
    logic [W-1:0] link_data;
    logic         link_tail;
    logic         link_valid;
    logic         link_ready;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: mode 0 = passing, 1 = draining, 2 = timed reset window
    int m_mode = 0, m_run = 0, m_t0 = 0, m_cyc = 0;
    bit m_in_pkt = 0, m_pend = 0;
    bit e_valid, e_ready, e_tail, e_busy, e_done, e_bub;

    // stimulus generator and link scoreboard
    int up_word = 0, rx_next = 0, word_in_pkt = 0, tail_len = 0;
    int done_cnt = 0;
    bit obs_tail, obs_done, obs_ready, obs_valid, obs_busy, obs_xfer, obs_acc;

    tail_bit_reset_tx #(
        .W(W), .RX_N(RX_N), .HOLD_CYCLES(HOLD), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rst_req    (rst_req),
        .data_in    (data_in),
        .data_tail  (data_tail),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .link_data  (link_data),
        .link_tail  (link_tail),
        .link_valid (link_valid),
        .link_ready (link_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic present();
        data_in = up_word[W-1:0];
        if (tail_len == 0) data_tail = ($urandom_range(0, 3) == 0);
        else               data_tail = (word_in_pkt == tail_len - 1);
    endtask

    task automatic model_expect();
        int k;
        e_valid = 0; e_ready = 0; e_tail = 0; e_busy = 0; e_done = 0;
        e_bub = (m_run == RX_N - 1);
        if (!reset) begin
            if (m_mode == 2) begin
                k = m_cyc - m_t0;
                e_tail = (k < HOLD);
                e_busy = 1;
                e_done = (k == HOLD + GUARD - 1);
            end else if (m_mode == 1 && !m_in_pkt) begin
                e_busy = 1;
            end else begin
                e_valid = data_valid && !e_bub;
                e_ready = link_ready && !e_bub;
                e_tail  = data_tail && e_valid;
                e_busy  = (m_mode == 1);
            end
        end
    endtask

    task automatic model_update();
        bit acc;
        acc = data_valid && e_ready;
        if (reset) begin
            m_mode = 0; m_in_pkt = 0; m_run = 0; m_pend = 0;
        end else if (m_mode == 2) begin
            m_run = 0;
            if (m_cyc - m_t0 == HOLD + GUARD - 1) m_mode = 0;
        end else begin
            m_run = e_tail ? m_run + 1 : 0;
            if (m_mode == 0) begin
                if (rst_req || m_pend) begin
                    if (e_bub) m_pend = 1;
                    else begin
                        m_pend = 0;
                        if (!m_in_pkt && !acc) begin m_mode = 2; m_t0 = m_cyc + 1; end
                        else m_mode = 1;
                    end
                end
            end else if (!m_in_pkt || (acc && data_tail)) begin
                m_mode = 2; m_t0 = m_cyc + 1;
            end
            if (acc) m_in_pkt = !data_tail;
        end
        m_cyc++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        model_expect();
        check_eq("link_valid", 32'(link_valid), 32'(e_valid));
        check_eq("data_ready", 32'(data_ready), 32'(e_ready));
        check_eq("link_tail",  32'(link_tail),  32'(e_tail));
        check_eq("busy",       32'(busy),       32'(e_busy));
        check_eq("done",       32'(done),       32'(e_done));
        if (e_valid) check_eq("link_data", 32'(link_data), 32'(data_in));
        obs_tail = link_tail; obs_done = done; obs_ready = data_ready;
        obs_valid = link_valid; obs_busy = busy;
        obs_xfer = link_valid && link_ready;
        obs_acc  = data_valid && data_ready;
        if (obs_xfer) begin
            check_eq("rx_order", 32'(link_data), 32'(rx_next[W-1:0]));
            rx_next++;
        end
        if (done) begin
            done_cnt++;
            $display("reset sequence done at cycle %0d", m_cyc);
        end
        @(posedge clk);
        model_update();
        #1;
        if (obs_acc) begin
            up_word++;
            word_in_pkt = data_tail ? 0 : word_in_pkt + 1;
            present();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int first_tail, last_tail, tail_cnt, done_at, xfers, gap, dc0;
        bit sent;

        reset = 1; rst_req = 0; data_valid = 0; link_ready = 1;
        tail_len = 4; present();
        idle(3);
        reset = 0;

        // idle link, single request pulse
        $display("scenario: idle request");
        idle(10);
        rst_req = 1; run_cycle(); rst_req = 0;
        first_tail = -1; last_tail = -1; tail_cnt = 0; done_at = -1;
        for (int off = 1; off <= 30; off++) begin
            run_cycle();
            if (obs_tail) begin
                if (first_tail < 0) first_tail = off;
                last_tail = off; tail_cnt++;
            end
            if (obs_done) done_at = off;
        end
        check_eq("idle_first_tail", first_tail, 1);
        check_eq("idle_last_tail",  last_tail,  HOLD);
        check_eq("idle_tail_count", tail_cnt,   HOLD);
        check_eq("idle_done_at",    done_at,    HOLD + GUARD);

        // request on word 2 of a 4-word packet
        $display("scenario: drain in-flight packet");
        tail_len = 4; word_in_pkt = 0; present();
        data_valid = 1; link_ready = 1; sent = 0;
        for (int i = 0; i < 10 && !sent; i++) begin
            rst_req = (word_in_pkt == 1);
            sent = rst_req;
            run_cycle();
            rst_req = 0;
        end
        xfers = 0; gap = -1;
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            if (obs_tail && !obs_valid && obs_busy) begin gap = i; break; end
            if (obs_xfer) xfers++;
        end
        check_eq("drain_words_after_req", xfers, 2);
        check_eq("drain_assert_start", gap, 2);
        data_valid = 0;
        idle(HOLD + GUARD + 2);

        // back-to-back single-word packets
        $display("scenario: tail run bubble");
        tail_len = 1; present();
        data_valid = 1; link_ready = 1;
        for (int i = 0; i < 9; i++) begin
            run_cycle();
            check_eq("b2b_tail",  32'(obs_tail),  32'((i % 3) != 2));
            check_eq("b2b_ready", 32'(obs_ready), 32'((i % 3) != 2));
        end
        data_valid = 0;
        idle(2);

        // link stalls while draining
        $display("scenario: stall during drain");
        tail_len = 3; word_in_pkt = 0; present();
        dc0 = done_cnt; xfers = 0;
        data_valid = 1; link_ready = 1; rst_req = 1;
        run_cycle(); if (obs_xfer) xfers++;
        rst_req = 0; link_ready = 0;
        for (int i = 0; i < 6; i++) begin run_cycle(); if (obs_xfer) xfers++; end
        link_ready = 1;
        for (int i = 0; i < 10; i++) begin run_cycle(); if (obs_xfer) xfers++; end
        data_valid = 0;
        idle(HOLD + GUARD);
        check_eq("stall_words", xfers, 3);
        check_eq("stall_done_count", done_cnt - dc0, 1);

        // reset in the middle of ASSERT
        $display("scenario: reset mid-assert");
        dc0 = done_cnt;
        rst_req = 1; run_cycle(); rst_req = 0;
        idle(3);
        reset = 1; run_cycle(); reset = 0;
        run_cycle();
        check_eq("midrst_tail", 32'(obs_tail), 32'(0));
        check_eq("midrst_busy", 32'(obs_busy), 32'(0));
        idle(30);
        check_eq("midrst_no_done", done_cnt - dc0, 0);

        // request held high through the whole sequence
        $display("scenario: request held through guard");
        dc0 = done_cnt;
        rst_req = 1;
        for (int i = 0; i <= HOLD + GUARD; i++) run_cycle();
        rst_req = 0;
        idle(20);
        check_eq("held_done_count", done_cnt - dc0, 1);

        // random traffic, requests and resets
        $display("scenario: random traffic");
        tail_len = 0; present();
        for (int i = 0; i < 2500; i++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            link_ready = ($urandom_range(0, 3) != 0);
            rst_req    = ($urandom_range(0, 49) == 0);
            reset      = ($urandom_range(0, 399) == 0);
            run_cycle();
        end
        reset = 0; rst_req = 0; data_valid = 0;
        idle(HOLD + GUARD + 4);
        check_eq("words_conserved", rx_next, up_word);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
